// File: rtl/vc_fifo.sv
// vc_fifo: virtual-channel input buffer. This is a circular buffer with a
// one-cycle registered read port. Its flags feed the arbiter's pop and pause logic.
//
// Ports:
//   clk          - single clock, rising-edge active
//   reset_L      - asynchronous active-low reset
//   push/data_in - write request and the word to store
//   pop          - read request from the arbiter
//   data_out     - registered read word, valid the cycle after an accepted pop
//   valid_out    - one-cycle strobe aligned with new data_out
//   empty/full/almost_full/almost_empty - decodes of the registered count
//   error        - sticky overflow/underflow flag
module vc_fifo #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_THRESH  = 6,
  parameter int unsigned AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_THRESH);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;

  logic pop_ok;
  logic push_ok;

  // A pop needs a stored word. A push into a full buffer is still accepted
  // when a pop frees a slot on the same edge.
  always_comb begin
    pop_ok  = pop && (count_q != '0);
    push_ok = push && ((count_q != CNT_FULL) || pop_ok);
  end

  // Next-state logic for the pointers, the count, the read port and the error flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    error_d    = error_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (pop_ok) begin
      rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
      data_out_d = mem_q[rd_ptr_q];
      valid_d    = 1'b1;
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
    if ((push && !push_ok) || (pop && !pop_ok)) begin
      error_d = 1'b1;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  // Storage array. It has no reset because stale contents are never read.
  // The read above samples the old word, so a full push+pop to the same
  // slot is safe.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out     = data_out_q;
  assign valid_out    = valid_q;
  assign error        = error_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_FULL);
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);

endmodule

// File: tb/tb_vc_fifo.sv
// Bench for vc_fifo. It keeps a queue model and compares every output against
// the model on each falling edge. Directed scenarios add literal expectations.
module tb_vc_fifo;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       push;
  logic [5:0] data_in;
  logic       pop;
  logic [5:0] data_out;
  logic       valid_out, empty, full, almost_full, almost_empty, error;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic [5:0] mq[$];
  logic [5:0] m_dout;
  logic       m_valid;
  logic       m_err;

  vc_fifo dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // The model works from the queue length and the acceptance rules, not from pointers.
  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      mq.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_err   = 1'b0;
    end else begin
      automatic bit pop_ok  = pop && (mq.size() > 0);
      automatic bit push_ok = push && ((mq.size() < 8) || pop_ok);
      if (pop_ok) begin
        m_dout  = mq.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (push_ok) mq.push_back(data_in);
      if ((push && !push_ok) || (pop && !pop_ok)) m_err = 1'b1;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    chk("m_data_out",     {2'b0, data_out},       {2'b0, m_dout});
    chk("m_valid_out",    {7'b0, valid_out},      {7'b0, m_valid});
    chk("m_empty",        {7'b0, empty},          {7'b0, mq.size() == 0});
    chk("m_full",         {7'b0, full},           {7'b0, mq.size() == 8});
    chk("m_almost_full",  {7'b0, almost_full},    {7'b0, mq.size() >= 6});
    chk("m_almost_empty", {7'b0, almost_empty},   {7'b0, mq.size() <= 1});
    chk("m_error",        {7'b0, error},          {7'b0, m_err});
  end

  // Apply the inputs for one edge, then return 1 time unit after that edge.
  task automatic cyc(input logic p, input logic [5:0] d, input logic po);
    push    = p;
    data_in = d;
    pop     = po;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    push = 0; pop = 0; data_in = '0;
    reset_L = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_L = 1'b1;
  endtask

  initial begin
    push = 0; pop = 0; data_in = '0;
    do_reset();
    chk("rst_empty",    {7'b0, empty},        8'd1);
    chk("rst_aempty",   {7'b0, almost_empty}, 8'd1);
    chk("rst_full",     {7'b0, full},         8'd0);
    chk("rst_afull",    {7'b0, almost_full},  8'd0);
    chk("rst_error",    {7'b0, error},        8'd0);
    chk("rst_dout",     {2'b0, data_out},     8'h00);
    chk("rst_valid",    {7'b0, valid_out},    8'd0);

    // Fill the buffer, then drain it in order.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 6'(i), 1'b0);
      if (i == 5) chk("fill_af5", {7'b0, almost_full}, 8'd0);
      if (i == 6) chk("fill_af6", {7'b0, almost_full}, 8'd1);
      if (i == 7) chk("fill_full7", {7'b0, full}, 8'd0);
    end
    chk("fill_full8", {7'b0, full}, 8'd1);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 6'h00, 1'b1);
      chk("drain_data",  {2'b0, data_out},  8'(i));
      chk("drain_valid", {7'b0, valid_out}, 8'd1);
    end
    cyc(1'b0, 6'h00, 1'b0);
    chk("drain_empty", {7'b0, empty},     8'd1);
    chk("drain_error", {7'b0, error},     8'd0);
    chk("drain_vdone", {7'b0, valid_out}, 8'd0);

    // Overflow: the dropped word must not appear in the drain.
    for (int i = 0; i < 8; i++) cyc(1'b1, 6'(8'h10 + i), 1'b0);
    cyc(1'b1, 6'h3F, 1'b0);
    chk("ovf_error", {7'b0, error}, 8'd1);
    chk("ovf_full",  {7'b0, full},  8'd1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 6'h00, 1'b1);
      chk("ovf_drain", {2'b0, data_out}, 8'(8'h10 + i));
    end
    cyc(1'b0, 6'h00, 1'b0);
    chk("ovf_empty", {7'b0, empty}, 8'd1);

    // Underflow: a pop while empty sets error and leaves valid_out low.
    do_reset();
    cyc(1'b0, 6'h00, 1'b1);
    chk("udf_error", {7'b0, error},     8'd1);
    chk("udf_valid", {7'b0, valid_out}, 8'd0);

    // Full buffer with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 6'(8'h20 + i), 1'b0);
    cyc(1'b1, 6'h2A, 1'b1);
    chk("fpp_data",  {2'b0, data_out}, 8'h20);
    chk("fpp_full",  {7'b0, full},     8'd1);
    chk("fpp_error", {7'b0, error},    8'd0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 6'h00, 1'b1);
      chk("fpp_drain", {2'b0, data_out}, (i == 8) ? 8'h2A : 8'(8'h20 + i));
    end

    // Empty buffer with simultaneous push and pop.
    do_reset();
    cyc(1'b1, 6'h15, 1'b1);
    chk("epp_error", {7'b0, error},     8'd1);
    chk("epp_empty", {7'b0, empty},     8'd0);
    chk("epp_aempt", {7'b0, almost_empty}, 8'd1);
    chk("epp_valid", {7'b0, valid_out}, 8'd0);
    cyc(1'b0, 6'h00, 1'b1);
    chk("epp_data",  {2'b0, data_out},  8'h15);
    chk("epp_vld",   {7'b0, valid_out}, 8'd1);

    // Wrap-around: hold the count at 3 for 20 cycles of push+pop.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 6'(8'h30 + i), 1'b0);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 6'(k), 1'b1);
      chk("wrap_data", {2'b0, data_out}, (k < 3) ? 8'(8'h30 + k) : 8'(k - 3));
      chk("wrap_ae",   {7'b0, almost_empty}, 8'd0);
    end
    cyc(1'b0, 6'h00, 1'b0);

    // Async reset between edges with 5 words stored and valid_out high.
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 6'(8'h08 + i), 1'b0);
    cyc(1'b0, 6'h00, 1'b1);
    chk("ar_pre_valid", {7'b0, valid_out}, 8'd1);
    chk("ar_pre_data",  {2'b0, data_out},  8'h08);
    #2 reset_L = 1'b0;
    #1;
    chk("ar_data",  {2'b0, data_out},     8'h00);
    chk("ar_valid", {7'b0, valid_out},    8'd0);
    chk("ar_empty", {7'b0, empty},        8'd1);
    chk("ar_aempt", {7'b0, almost_empty}, 8'd1);
    chk("ar_error", {7'b0, error},        8'd0);
    @(posedge clk);
    #3 reset_L = 1'b1;
    cyc(1'b0, 6'h00, 1'b1);
    chk("ar_post_error", {7'b0, error},     8'd1);
    chk("ar_post_valid", {7'b0, valid_out}, 8'd0);

    cyc(1'b0, 6'h00, 1'b0);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
